eth_rx_frame_buffer: RTL and testbench
======================================

# eth_rx_frame_buffer

Receive-side frame buffer between the Ethernet MAC byte stream and the MHP protocol engine's pull-style read port. It stores incoming bytes in a circular buffer and exposes a frame only once it has been fully received without error, so the protocol engine never sees partial or bad frames. Frames that hit a MAC error or overflow the buffer are rolled back and counted.

## Interface
- `DEPTH`, 2048: buffer size in bytes; power of 2, minimum 64.
- `ETYPE`, 16'h88B5: accepted ethertype, used only when the filter is compiled in.
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_mac_data`, in, 8: received byte.
- `i_mac_valid`, in, 1: byte strobe. The MAC cannot be stalled.
- `i_mac_last`, in, 1: qualifies the final byte of a frame.
- `i_mac_err`, in, 1: frame bad (FCS or PHY error); sampled with `i_mac_last`.
- `o_rdata`, out, 8: head byte, first-word-fall-through.
- `o_rready`, out, 1: a committed byte is available.
- `i_rreq`, in, 1: pop the head byte.
- `o_rlast`, out, 1: the head byte is the last byte of its frame.
- `o_drop_cnt`, out, 16: saturating count of discarded frames.
- `o_overflow`, out, 1: one-cycle pulse when a frame is dropped because the buffer is full.

## Operation
- Storage is 9 bits per entry: `{last, data}`.
- Pointers are `$clog2(DEPTH)+1` bits wide and wrap naturally:
  - `wr_ptr`: speculative write pointer.
  - `wr_cmt`: committed write pointer.
  - `rd_ptr`: read pointer.
- Status conditions:
  - full = `(wr_ptr - rd_ptr) == DEPTH`.
  - `o_rready` = `(rd_ptr != wr_cmt)`.
- Write FSM states: IDLE, RECV, DROP.
  - IDLE → RECV on a valid byte. That byte is written, and the byte counter is set to 1.
  - RECV: each valid byte is written at `wr_ptr`, `wr_ptr` increments, and the byte counter increments, saturating at 2047.
  - RECV on the last byte, good frame: write the byte with last=1, then `wr_cmt <= wr_ptr+1` → IDLE.
  - RECV on the last byte with `i_mac_err`: `wr_ptr <= wr_cmt` (rollback), increment the drop count → IDLE.
  - RECV, valid byte while full: rollback, increment the drop count, pulse `o_overflow`. Go to DROP, or go straight to IDLE if that byte is the last byte.
  - DROP: discard all bytes until a last byte → IDLE. No second drop count for the same frame.
  - A single-byte frame (valid and last in IDLE) follows the same commit and drop rules.
- Read side:
  - `o_rdata` and `o_rlast` come combinationally from `mem[rd_ptr]`.
  - `i_rreq` while `o_rready` is high advances `rd_ptr`.
  - `i_rreq` while `o_rready` is low is ignored.
- Simultaneous read and write in the same cycle are independent. The full test uses the pre-edge `rd_ptr`, so a pop in the same cycle does not free space for that cycle's write.
- `o_drop_cnt` saturates at 16'hFFFF.

## Timing
- Reset values: all pointers 0, state IDLE, `o_rready`=0, `o_rlast`=0 (memory content is don't-care, output masked), `o_drop_cnt`=0, `o_overflow`=0.
- Commit latency: `o_rready` rises on the first cycle after the edge that wrote the last byte.
- Read: zero-latency FWFT. After a pop, the next byte is presented in the following cycle.
- Back-to-back frames: a new frame may start in the cycle immediately after a last byte.
- Reset mid-frame: the partial frame is lost and committed frames are flushed. A byte arriving after reset deasserts is treated as the start of a new frame.
- Maximum committed occupancy is DEPTH bytes. A frame longer than DEPTH is always dropped.

## Configuration
- `ETH_RX_ETYPE_FILTER_EN` defined:
  - Bytes 12 and 13 (big-endian) are captured into an ethertype register.
  - On a good last byte, the frame commits only if the frame is at least 14 bytes and the ethertype equals `ETYPE`. Otherwise it is rolled back and counted in `o_drop_cnt`; `o_overflow` does not pulse.
- Undefined: every error-free, non-overflowing frame commits. The `ETYPE` parameter is unused.

## Structure
- Shared package `eth_pkg` holds:
  - FSM state encoding: `RX_IDLE`, `RX_RECV`, `RX_DROP`.
  - Ethernet constants: `ETH_ETYPE_OFS` = 12, `ETH_HDR_LEN` = 14.
  - Default `ETYPE`.
- One sub-module, `eth_rx_ram`: simple dual-port RAM, DEPTH×9, synchronous write, asynchronous read.

## Test plan
- 64-byte good frame, then the reader pops continuously:
  - `o_rready` rises 1 cycle after the last byte.
  - Reader gets 64 bytes in order, `o_rlast` only on byte 64.
  - `o_rready` falls after the pop of byte 64.
- 60-byte frame with `i_mac_err` on the last byte: `o_rready` stays 0, `o_drop_cnt`=1, next good frame is delivered intact.
- DEPTH=64, reader stalled, two 40-byte frames:
  - First frame commits.
  - Second overflows: `o_overflow` pulses once, `o_drop_cnt`=1.
  - After popping 40 bytes, `o_rready`=0.
- Reset asserted at byte 20 of a frame, then a 10-byte good frame: only the 10-byte frame is read out.
- Back-to-back 1-byte frames (values 8'hA5, 8'h5A) with a concurrent reader: two pops, each with `o_rlast`=1.
- With `ETH_RX_ETYPE_FILTER_EN`:
  - Ethertype 16'h0800 → dropped, count 1.
  - 16'h88B5 → delivered.
  - 10-byte frame → dropped, count 2.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: FSM states, header constants, buffer entry.
package eth_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_DROP
  } rx_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  localparam int          ETH_ETYPE_OFS = 12;
  localparam int          ETH_HDR_LEN   = 14;
  localparam logic [15:0] ETH_ETYPE_DEF = 16'h88B5;

endpackage

// File: rtl/eth_rx_ram.sv
// Simple dual-port RAM, DEPTH x {last,data}.
// Synchronous write, asynchronous read.
module eth_rx_ram
  import eth_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rx_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output rx_entry_t     rdata
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// RX frame buffer: frames become readable only once fully received and good.
// Optional ethertype filter enabled by defining ETH_RX_ETYPE_FILTER_EN.
module eth_rx_frame_buffer
  import eth_pkg::*;
#(
  parameter int          DEPTH = 2048,
  parameter logic [15:0] ETYPE = ETH_ETYPE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_mac_data,
  input  logic        i_mac_valid,
  input  logic        i_mac_last,
  input  logic        i_mac_err,
  output logic [7:0]  o_rdata,
  output logic        o_rready,
  input  logic        i_rreq,
  output logic        o_rlast,
  output logic [15:0] o_drop_cnt,
  output logic        o_overflow
);

  localparam int         AW      = $clog2(DEPTH);
  localparam int         PW      = AW + 1;
  localparam logic [10:0] CNT_MAX = 11'd2047;

  rx_state_t     state, state_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [PW-1:0] wr_cmt, wr_cmt_d;
  logic [PW-1:0] rd_ptr;
  logic [10:0]   cnt, cnt_d, idx;
  logic          we, drop, ovf;
  logic          full, frame_ok, pop;
  rx_entry_t     wentry, rentry;

`ifdef ETH_RX_ETYPE_FILTER_EN
  logic [15:0] etype, etype_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ETYPE, idx};
`endif

  // Pre-edge rd_ptr: a same-cycle pop does not free room for this write.
  assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign o_rready = rd_ptr != wr_cmt;
  assign pop      = i_rreq && o_rready;
  assign wentry   = '{last: i_mac_last, data: i_mac_data};
  assign o_rdata  = o_rready ? rentry.data : 8'h00;
  assign o_rlast  = o_rready && rentry.last;

  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    wr_cmt_d = wr_cmt;
    cnt_d    = cnt;
    we       = 1'b0;
    drop     = 1'b0;
    ovf      = 1'b0;
    idx      = (state == RX_IDLE) ? 11'd0 : cnt;
`ifdef ETH_RX_ETYPE_FILTER_EN
    etype_d = etype;
    if (i_mac_valid && idx == 11'(ETH_ETYPE_OFS))
      etype_d[15:8] = i_mac_data;
    if (i_mac_valid && idx == 11'(ETH_ETYPE_OFS + 1))
      etype_d[7:0] = i_mac_data;
    frame_ok = (idx >= 11'(ETH_HDR_LEN - 1)) &&
               (etype_d == ETYPE);
`else
    frame_ok = 1'b1;
`endif
    unique case (state)
      RX_IDLE, RX_RECV: begin
        if (i_mac_valid) begin
          if (full) begin
            wr_ptr_d = wr_cmt;
            drop     = 1'b1;
            ovf      = 1'b1;
            state_d  = i_mac_last ? RX_IDLE : RX_DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr + PW'(1);
            if (state == RX_IDLE)   cnt_d = 11'd1;
            else if (cnt != CNT_MAX) cnt_d = cnt + 11'd1;
            if (!i_mac_last) begin
              state_d = RX_RECV;
            end else begin
              state_d = RX_IDLE;
              if (i_mac_err || !frame_ok) begin
                wr_ptr_d = wr_cmt;
                drop     = 1'b1;
              end else begin
                wr_cmt_d = wr_ptr + PW'(1);
              end
            end
          end
        end
      end
      RX_DROP: begin
        if (i_mac_valid && i_mac_last) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= RX_IDLE;
      wr_ptr     <= '0;
      wr_cmt     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      o_drop_cnt <= '0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      wr_cmt     <= wr_cmt_d;
      cnt        <= cnt_d;
      o_overflow <= ovf;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (drop && o_drop_cnt != 16'hFFFF)
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

`ifdef ETH_RX_ETYPE_FILTER_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) etype <= '0;
    else       etype <= etype_d;
  end
`endif

  eth_rx_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk (i_clk),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wentry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rentry)
  );

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: directed scenarios plus random traffic
// checked every cycle against a frame-level queue model.
module tb_eth_rx_frame_buffer;
  localparam int          DEPTH = 64;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_mac_data = 8'h00;
  logic        i_mac_valid = 1'b0;
  logic        i_mac_last = 1'b0;
  logic        i_mac_err = 1'b0;
  logic        i_rreq = 1'b0;
  logic [7:0]  o_rdata;
  logic        o_rready;
  logic        o_rlast;
  logic [15:0] o_drop_cnt;
  logic        o_overflow;

  always #5 i_clk = ~i_clk;

  eth_rx_frame_buffer #(
    .DEPTH (DEPTH),
    .ETYPE (ETYPE)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mac_data  (i_mac_data),
    .i_mac_valid (i_mac_valid),
    .i_mac_last  (i_mac_last),
    .i_mac_err   (i_mac_err),
    .o_rdata     (o_rdata),
    .o_rready    (o_rready),
    .i_rreq      (i_rreq),
    .o_rlast     (o_rlast),
    .o_drop_cnt  (o_drop_cnt),
    .o_overflow  (o_overflow)
  );

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int lasts = 0;
  int ovf_seen = 0;

  // Model: committed bytes awaiting read, bytes of the frame in flight.
  logic [8:0] q[$];
  logic [8:0] pend[$];
  bit         mdrop = 0;
  int         exp_drop = 0;
  bit         exp_ovf = 0;

  function automatic bit frame_ok();
`ifdef ETH_RX_ETYPE_FILTER_EN
    if (pend.size() < 14) return 1'b0;
    return {pend[12][7:0], pend[13][7:0]} == ETYPE;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void count_drop();
    if (exp_drop < 65535) exp_drop++;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d,
                            input logic l, input logic e,
                            input logic r);
    bit full;
    full = (q.size() + pend.size()) == DEPTH;
    if (r && q.size() != 0) void'(q.pop_front());
    exp_ovf = 1'b0;
    if (v) begin
      if (mdrop) begin
        if (l) mdrop = 1'b0;
      end else if (full) begin
        pend.delete();
        count_drop();
        exp_ovf = 1'b1;
        mdrop = !l;
      end else begin
        pend.push_back({l, d});
        if (l) begin
          if (!e && frame_ok())
            foreach (pend[k]) q.push_back(pend[k]);
          else
            count_drop();
          pend.delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic v, input logic [7:0] d,
                      input logic l, input logic e,
                      input logic r, input logic rst);
    chk("rready", {15'd0, o_rready}, {15'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("rdata", {8'd0, o_rdata}, {8'd0, q[0][7:0]});
      chk("rlast", {15'd0, o_rlast}, {15'd0, q[0][8]});
    end
    chk("drop_cnt", o_drop_cnt, exp_drop[15:0]);
    chk("overflow", {15'd0, o_overflow}, {15'd0, exp_ovf});
    if (o_overflow) ovf_seen++;
    i_rst = rst;
    i_mac_valid = v;
    i_mac_data = d;
    i_mac_last = l;
    i_mac_err = e;
    i_rreq = r;
    if (r && o_rready) begin
      pops++;
      if (o_rlast) lasts++;
    end
    @(posedge i_clk);
    if (rst) begin
      q.delete();
      pend.delete();
      mdrop = 1'b0;
      exp_drop = 0;
      exp_ovf = 1'b0;
    end else begin
      model_edge(v, d, l, e, r);
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n, input int rd_pct);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'h00, 1'b0, 1'b0,
           $urandom_range(99) < rd_pct, 1'b0);
  endtask

  task automatic send_frame(input int len, input bit err,
                            input logic [15:0] et, input int rd_pct);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i == 12) b = et[15:8];
      if (i == 13) b = et[7:0];
      step(1'b1, b, i == len - 1, err && (i == len - 1),
           $urandom_range(99) < rd_pct, 1'b0);
    end
  endtask

  initial begin
    int n_exp;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_rready", {15'd0, o_rready}, 16'd0);
    chk("rst_rlast", {15'd0, o_rlast}, 16'd0);
    chk("rst_drop", o_drop_cnt, 16'd0);
    chk("rst_ovf", {15'd0, o_overflow}, 16'd0);
    idle(2, 0);

    send_frame(64, 1'b0, ETYPE, 0);
    chk("commit64", {15'd0, o_rready}, 16'd1);
    pops = 0;
    lasts = 0;
    idle(66, 100);
    chk("pops64", 16'(pops), 16'd64);
    chk("lasts64", 16'(lasts), 16'd1);
    chk("empty64", {15'd0, o_rready}, 16'd0);

    send_frame(60, 1'b1, ETYPE, 0);
    idle(2, 0);
    chk("err_rready", {15'd0, o_rready}, 16'd0);
    chk("err_drop", o_drop_cnt, 16'd1);
    send_frame(30, 1'b0, ETYPE, 50);
    idle(40, 100);
    chk("err_next_empty", {15'd0, o_rready}, 16'd0);

    ovf_seen = 0;
    send_frame(40, 1'b0, ETYPE, 0);
    chk("ovf_first", {15'd0, o_rready}, 16'd1);
    send_frame(40, 1'b0, ETYPE, 0);
    idle(2, 0);
    chk("ovf_pulses", 16'(ovf_seen), 16'd1);
    chk("ovf_drop", o_drop_cnt, 16'd2);
    pops = 0;
    idle(45, 100);
    chk("ovf_pops", 16'(pops), 16'd40);
    chk("ovf_empty", {15'd0, o_rready}, 16'd0);

    for (int i = 0; i < 20; i++)
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(10, 1'b0, ETYPE, 0);
    pops = 0;
    idle(12, 100);
`ifdef ETH_RX_ETYPE_FILTER_EN
    n_exp = 0;
`else
    n_exp = 10;
`endif
    chk("rstmid_pops", 16'(pops), 16'(n_exp));

    pops = 0;
    lasts = 0;
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 100);
`ifdef ETH_RX_ETYPE_FILTER_EN
    n_exp = 0;
`else
    n_exp = 2;
`endif
    chk("b2b_pops", 16'(pops), 16'(n_exp));
    chk("b2b_lasts", 16'(lasts), 16'(n_exp));

`ifdef ETH_RX_ETYPE_FILTER_EN
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(20, 1'b0, 16'h0800, 0);
    idle(1, 0);
    chk("flt_ip_drop", o_drop_cnt, 16'd1);
    chk("flt_ip_rready", {15'd0, o_rready}, 16'd0);
    send_frame(20, 1'b0, 16'h88B5, 0);
    chk("flt_ok_rready", {15'd0, o_rready}, 16'd1);
    pops = 0;
    idle(22, 100);
    chk("flt_ok_pops", 16'(pops), 16'd20);
    send_frame(10, 1'b0, 16'h88B5, 0);
    idle(1, 0);
    chk("flt_short_drop", o_drop_cnt, 16'd2);
`endif

    for (int f = 0; f < 25; f++) begin
      logic [15:0] et;
      et = ($urandom_range(3) == 0) ? 16'h0800 : ETYPE;
      send_frame($urandom_range(90, 1), $urandom_range(7) == 0,
                 et, $urandom_range(100));
      idle($urandom_range(3), 50);
    end
    idle(100, 100);
    chk("final_empty", {15'd0, o_rready}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
